// File: rtl/coeff_ahb_loader_if.sv
// Stream + AHB-Lite bundle for the coefficient loader.
// master: loader side; slave: host source and bank port side.
interface coeff_ahb_loader_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;

    modport master (
        input  s_data, s_valid, hready, hresp,
        output s_ready, haddr, htrans, hwrite, hsize, hwdata
    );

    modport slave (
        output s_data, s_valid, hready, hresp,
        input  s_ready, haddr, htrans, hwrite, hsize, hwdata
    );
endinterface

// File: rtl/coeff_ahb_loader.sv
// AHB-Lite write initiator: uploads NUM_COEFF signed 16-bit coefficients,
// one single NONSEQ word write each, into the coefficient bank.
// Ports: clk, rst (async active-low), start, bus (stream s_* and AHB h*),
// busy, done (1-cycle pulse), err (sticky), checksum.
// Optional: COEFF_LOAD_CHECKSUM_EN enables the mod-2^16 coefficient sum;
// otherwise checksum is tied to zero.
module coeff_ahb_loader #(
    parameter int          NUM_COEFF   = 25,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_STRIDE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    coeff_ahb_loader_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         checksum
);

    localparam int IDX_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_COEFF - 1);
    localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);

    typedef enum logic [2:0] {
        IDLE, FETCH, ADDR, DATA, DONE, ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic [31:0]      haddr_q, haddr_d;
    logic [1:0]       htrans_q, htrans_d;
    logic             hwrite_q, hwrite_d;
    logic             s_ready_q, s_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Next state and data path; outputs are decoded from the next state
    // so every bus output comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hwdata_d = hwdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.s_valid) begin
                    hwdata_d = {{16{bus.s_data[15]}}, bus.s_data};
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (bus.hready) state_d = DATA;
            end
            DATA: begin
                if (bus.hready) begin
                    if (bus.hresp) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        s_ready_d = (state_d == FETCH);
        htrans_d  = (state_d == ADDR) ? 2'b10 : 2'b00;
        hwrite_d  = (state_d == ADDR);
        haddr_d   = (state_d == ADDR)
                  ? BASE_ADDR + 32'(idx_d) * STRIDE
                  : 32'h0;
        busy_d    = (state_d == FETCH) || (state_d == ADDR)
                  || (state_d == DATA);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            hwdata_q  <= '0;
            haddr_q   <= '0;
            htrans_q  <= 2'b00;
            hwrite_q  <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hwdata_q  <= hwdata_d;
            haddr_q   <= haddr_d;
            htrans_q  <= htrans_d;
            hwrite_q  <= hwrite_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.haddr   = haddr_q;
    assign bus.htrans  = htrans_q;
    assign bus.hwrite  = hwrite_q;
    assign bus.hsize   = 3'b010;
    assign bus.hwdata  = hwdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

`ifdef COEFF_LOAD_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && start) begin
            sum_d = '0;
        end else if (state_q == FETCH && bus.s_valid) begin
            sum_d = sum_q + bus.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sum_q <= '0;
        else      sum_q <= sum_d;
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule
